// File: rtl/issueq_request_ctrl.sv
// rtl/issueq_request_ctrl.sv - issue-queue entry valid/ready state, select-tree requester, registered issue slot
// Optional ISSUEQ_WAKEUP_BYPASS_EN: same-cycle wakeup-to-request bypass.
module issueq_request_ctrl #(
   parameter int SIZE_ISSUEQ     = 32,
   parameter int SIZE_ISSUEQ_LOG = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       dispatchValid_i,
   input  logic                       dispatchReady_i,
   output logic                       dispatchReady_o,
   output logic [SIZE_ISSUEQ_LOG-1:0] dispatchEntry_o,
   input  logic [SIZE_ISSUEQ-1:0]     wakeupVector_i,
   input  logic                       stall_i,
   input  logic                       flush_i,
   output logic [SIZE_ISSUEQ-1:0]     requestVector_o,
   output logic                       grant_o,
   input  logic                       grantedValid_i,
   input  logic [SIZE_ISSUEQ_LOG-1:0] grantedEntry_i,
   output logic                       issueValid_o,
   output logic [SIZE_ISSUEQ_LOG-1:0] issueEntry_o,
   output logic [SIZE_ISSUEQ_LOG:0]   freeCount_o
);

   localparam logic [SIZE_ISSUEQ_LOG:0] FULL_COUNT = (SIZE_ISSUEQ_LOG+1)'(SIZE_ISSUEQ);
   localparam logic [SIZE_ISSUEQ_LOG:0] ONE        = (SIZE_ISSUEQ_LOG+1)'(1);

   logic [SIZE_ISSUEQ-1:0]     valid, ready, valid_n, ready_n;
   logic                       issue_valid;
   logic [SIZE_ISSUEQ_LOG-1:0] issue_entry;
   logic [SIZE_ISSUEQ_LOG:0]   free_count, free_count_n;
   logic [SIZE_ISSUEQ_LOG-1:0] alloc_entry;
   logic                       alloc, accept;

   // Lowest-index free entry, taken from registered valid so an entry freed
   // this cycle is only reusable on the next one.
   always_comb begin
      alloc_entry = '0;
      for (int i = SIZE_ISSUEQ-1; i >= 0; i--) begin
         if (!valid[i]) alloc_entry = SIZE_ISSUEQ_LOG'(i);
      end
   end

   assign dispatchReady_o = (free_count != '0);
   assign dispatchEntry_o = dispatchReady_o ? alloc_entry : '0;

`ifdef ISSUEQ_WAKEUP_BYPASS_EN
   assign requestVector_o = valid & (ready | wakeupVector_i);
`else
   assign requestVector_o = valid & ready;
`endif

   assign grant_o = ~stall_i & (|requestVector_o);
   assign accept  = grantedValid_i & grant_o & requestVector_o[grantedEntry_i];
   assign alloc   = dispatchValid_i & dispatchReady_o;

   // The allocated entry is free and the granted one is valid, so they never collide.
   always_comb begin
      valid_n = valid;
      ready_n = ready | (wakeupVector_i & valid);
      if (alloc) begin
         valid_n[alloc_entry] = 1'b1;
         ready_n[alloc_entry] = dispatchReady_i | wakeupVector_i[alloc_entry];
      end
      if (accept) begin
         valid_n[grantedEntry_i] = 1'b0;
         ready_n[grantedEntry_i] = 1'b0;
      end
   end

   always_comb begin
      free_count_n = free_count;
      case ({alloc, accept})
         2'b10:   free_count_n = free_count - ONE;
         2'b01:   free_count_n = free_count + ONE;
         default: free_count_n = free_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         valid       <= '0;
         ready       <= '0;
         issue_valid <= 1'b0;
         issue_entry <= '0;
         free_count  <= FULL_COUNT;
      end else if (flush_i) begin
         valid       <= '0;
         ready       <= '0;
         issue_valid <= 1'b0;
         free_count  <= FULL_COUNT;
      end else begin
         valid       <= valid_n;
         ready       <= ready_n;
         issue_valid <= accept;
         free_count  <= free_count_n;
         if (accept) issue_entry <= grantedEntry_i;
      end
   end

   assign issueValid_o = issue_valid;
   assign issueEntry_o = issue_entry;
   assign freeCount_o  = free_count;

endmodule

// File: tb/tb_issueq_request_ctrl.sv
// tb/tb_issueq_request_ctrl.sv - scoreboard bench for issueq_request_ctrl with a lowest-index select tree model
module tb_issueq_request_ctrl;

   localparam int N = 32;
   localparam int L = 5;

   logic         clk, reset;
   logic         dispatchValid_i, dispatchReady_i, dispatchReady_o;
   logic [L-1:0] dispatchEntry_o;
   logic [N-1:0] wakeupVector_i;
   logic         stall_i, flush_i;
   logic [N-1:0] requestVector_o;
   logic         grant_o, grantedValid_i;
   logic [L-1:0] grantedEntry_i;
   logic         issueValid_o;
   logic [L-1:0] issueEntry_o;
   logic [L:0]   freeCount_o;

   logic         man_en, man_valid;
   logic [L-1:0] man_entry;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   issueq_request_ctrl #(.SIZE_ISSUEQ(N), .SIZE_ISSUEQ_LOG(L)) dut (
      .clk(clk), .reset(reset),
      .dispatchValid_i(dispatchValid_i), .dispatchReady_i(dispatchReady_i),
      .dispatchReady_o(dispatchReady_o), .dispatchEntry_o(dispatchEntry_o),
      .wakeupVector_i(wakeupVector_i), .stall_i(stall_i), .flush_i(flush_i),
      .requestVector_o(requestVector_o), .grant_o(grant_o),
      .grantedValid_i(grantedValid_i), .grantedEntry_i(grantedEntry_i),
      .issueValid_o(issueValid_o), .issueEntry_o(issueEntry_o),
      .freeCount_o(freeCount_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Select tree: lowest-index requester, unless a test forces the grant.
   always_comb begin
      grantedValid_i = 1'b0;
      grantedEntry_i = '0;
      if (man_en) begin
         grantedValid_i = man_valid;
         grantedEntry_i = man_entry;
      end else begin
         for (int i = N-1; i >= 0; i--) begin
            if (requestVector_o[i]) begin
               grantedValid_i = 1'b1;
               grantedEntry_i = L'(i);
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (issueValid_o) begin
         if (exp_q.size() == 0) check_eq("spurious_issue", {59'd0, issueEntry_o}, 64'hFFFF);
         else check_eq("issue_entry", {59'd0, issueEntry_o}, 64'(exp_q.pop_front()));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic dispatch_n(input int n, input logic [N-1:0] rdy_mask);
      for (int i = 0; i < n; i++) begin
         dispatchValid_i = 1'b1;
         dispatchReady_i = rdy_mask[i];
         settle();
         check_eq("dispatch_entry", {59'd0, dispatchEntry_o}, 64'(i));
         tick();
      end
      dispatchValid_i = 1'b0;
      dispatchReady_i = 1'b0;
   endtask

   task automatic do_flush;
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      settle();
      check_eq("flush_free", {58'd0, freeCount_o}, 64'd32);
   endtask

   initial begin
      reset = 1'b0; dispatchValid_i = 1'b0; dispatchReady_i = 1'b0;
      wakeupVector_i = '0; stall_i = 1'b0; flush_i = 1'b0;
      man_en = 1'b1; man_valid = 1'b0; man_entry = '0;

      // Reset state
      tick(); tick(); settle();
      check_eq("rst_free", {58'd0, freeCount_o}, 64'd32);
      check_eq("rst_dready", {63'd0, dispatchReady_o}, 64'd1);
      check_eq("rst_dentry", {59'd0, dispatchEntry_o}, 64'd0);
      check_eq("rst_req", {32'd0, requestVector_o}, 64'd0);
      check_eq("rst_grant", {63'd0, grant_o}, 64'd0);
      check_eq("rst_issue", {63'd0, issueValid_o}, 64'd0);
      check_eq("rst_ientry", {59'd0, issueEntry_o}, 64'd0);
      reset = 1'b1;
      tick();

      // Three ready dispatches, then issue in order
      dispatch_n(3, 32'h7);
      settle();
      check_eq("t2_free", {58'd0, freeCount_o}, 64'd29);
      check_eq("t2_req", {32'd0, requestVector_o}, 64'h7);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
      man_en = 1'b0;
      settle();
      check_eq("t2_grant", {63'd0, grant_o}, 64'd1);
      check_eq("t2_no_issue_yet", {63'd0, issueValid_o}, 64'd0);
      for (int k = 0; k < 3; k++) begin
         tick(); settle();
         check_eq("t2_issue_lat", {63'd0, issueValid_o}, 64'd1);
      end
      tick(); settle();
      check_eq("t2_idle", {63'd0, issueValid_o}, 64'd0);
      check_eq("t2_free_back", {58'd0, freeCount_o}, 64'd32);

      // Fill queue with unready entries, drop extra dispatch, wake entry 4
      man_en = 1'b1; man_valid = 1'b0;
      do_flush();
      tick();
      dispatch_n(32, 32'h0);
      settle();
      check_eq("full_free", {58'd0, freeCount_o}, 64'd0);
      check_eq("full_dready", {63'd0, dispatchReady_o}, 64'd0);
      check_eq("full_dentry", {59'd0, dispatchEntry_o}, 64'd0);
      check_eq("full_req", {32'd0, requestVector_o}, 64'd0);
      dispatchValid_i = 1'b1;
      tick();
      dispatchValid_i = 1'b0;
      settle();
      check_eq("full_drop", {58'd0, freeCount_o}, 64'd0);
      exp_q.push_back(4);
      man_en = 1'b0;
      wakeupVector_i = 32'h0000_0010;
      settle();
`ifdef ISSUEQ_WAKEUP_BYPASS_EN
      check_eq("wk_req_same", {32'd0, requestVector_o}, 64'h10);
      check_eq("wk_grant_same", {63'd0, grant_o}, 64'd1);
      tick();
      wakeupVector_i = '0;
      settle();
`else
      check_eq("wk_req_same", {32'd0, requestVector_o}, 64'h0);
      check_eq("wk_grant_same", {63'd0, grant_o}, 64'd0);
      tick();
      wakeupVector_i = '0;
      settle();
      check_eq("wk_req_next", {32'd0, requestVector_o}, 64'h10);
      check_eq("wk_grant_next", {63'd0, grant_o}, 64'd1);
      tick(); settle();
`endif
      check_eq("wk_issued", {63'd0, issueValid_o}, 64'd1);
      check_eq("wk_dready", {63'd0, dispatchReady_o}, 64'd1);
      check_eq("wk_dentry", {59'd0, dispatchEntry_o}, 64'd4);
      check_eq("wk_free", {58'd0, freeCount_o}, 64'd1);
      tick(); settle();
      check_eq("wk_idle", {63'd0, issueValid_o}, 64'd0);

      // Stall blocks grants, release issues 2 then 5
      man_en = 1'b1; man_valid = 1'b0;
      do_flush();
      tick();
      dispatch_n(6, 32'h24);
      exp_q.push_back(2); exp_q.push_back(5);
      stall_i = 1'b1;
      man_en = 1'b0;
      for (int s = 0; s < 3; s++) begin
         settle();
         check_eq("stall_grant", {63'd0, grant_o}, 64'd0);
         check_eq("stall_req", {32'd0, requestVector_o}, 64'h24);
         check_eq("stall_issue", {63'd0, issueValid_o}, 64'd0);
         tick();
      end
      stall_i = 1'b0;
      settle();
      check_eq("unstall_grant", {63'd0, grant_o}, 64'd1);
      tick(); settle();
      check_eq("unstall_issue1", {63'd0, issueValid_o}, 64'd1);
      tick(); settle();
      check_eq("unstall_issue2", {63'd0, issueValid_o}, 64'd1);
      tick(); settle();
      check_eq("unstall_idle", {63'd0, issueValid_o}, 64'd0);
      check_eq("unstall_free", {58'd0, freeCount_o}, 64'd28);

      // Grant to a valid but non-requesting entry is ignored
      man_en = 1'b1; man_valid = 1'b0;
      wakeupVector_i = 32'h8;
      tick();
      wakeupVector_i = '0;
      man_valid = 1'b1; man_entry = 5'd0;
      settle();
      check_eq("bad_req", {32'd0, requestVector_o}, 64'h8);
      check_eq("bad_grant_en", {63'd0, grant_o}, 64'd1);
      tick();
      man_valid = 1'b0;
      settle();
      check_eq("bad_no_issue", {63'd0, issueValid_o}, 64'd0);
      check_eq("bad_free", {58'd0, freeCount_o}, 64'd28);
      check_eq("bad_req_kept", {32'd0, requestVector_o}, 64'h8);

      // Flush overrides dispatch and accepted grant
      do_flush();
      tick();
      dispatch_n(8, 32'hFF);
      settle();
      check_eq("fl_req", {32'd0, requestVector_o}, 64'hFF);
      flush_i = 1'b1; dispatchValid_i = 1'b1; dispatchReady_i = 1'b1;
      man_en = 1'b0;
      settle();
      check_eq("fl_grant", {63'd0, grant_o}, 64'd1);
      tick();
      flush_i = 1'b0; dispatchValid_i = 1'b0; dispatchReady_i = 1'b0;
      man_en = 1'b1; man_valid = 1'b0;
      settle();
      check_eq("fl_issue", {63'd0, issueValid_o}, 64'd0);
      check_eq("fl_free", {58'd0, freeCount_o}, 64'd32);
      check_eq("fl_req_clr", {32'd0, requestVector_o}, 64'd0);
      check_eq("fl_dentry", {59'd0, dispatchEntry_o}, 64'd0);

      // Reset during an accepted grant to entry 3
      dispatch_n(4, 32'hF);
      man_valid = 1'b1; man_entry = 5'd3;
      reset = 1'b0;
      settle();
      check_eq("rg_grant", {63'd0, grant_o}, 64'd1);
      tick();
      reset = 1'b1; man_valid = 1'b0;
      settle();
      check_eq("rg_issue", {63'd0, issueValid_o}, 64'd0);
      check_eq("rg_free", {58'd0, freeCount_o}, 64'd32);
      check_eq("rg_req", {32'd0, requestVector_o}, 64'd0);
      tick(); tick();

      check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
